// File: rtl/jedro_1_dbus_bridge_if.sv
// LSU-side strobe bus of the jedro-1 data-bus bridge.
// The LSU is the master; the bridge is the slave.
interface jedro_1_dbus_bridge_if;
  logic        stb;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (output stb, we, addr, wdata, input rdata, ack, err);
  modport slave  (input stb, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/jedro_1_dbus_bridge.sv
// jedro-1 data-bus bridge: decodes LSU strobes to block RAM, a req/ack peripheral
// port with timeout, or an unmapped-address error, and returns ack/err plus read data.
module jedro_1_dbus_bridge #(
  parameter logic [31:0] RAM_BASE      = 32'h8000_0000,
  parameter int          RAM_SIZE_LOG2 = 14,
  parameter logic [31:0] PER_BASE      = 32'h4000_0000,
  parameter int          PER_SIZE_LOG2 = 16,
  parameter int          TIMEOUT       = 15
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  jedro_1_dbus_bridge_if.slave     lsu,
  output logic                     overrun_o,
  output logic                     bram_en_o,
  output logic [3:0]               bram_we_o,
  output logic [RAM_SIZE_LOG2-3:0] bram_addr_o,
  output logic [31:0]              bram_wdata_o,
  input  logic [31:0]              bram_rdata_i,
  output logic                     per_req_o,
  output logic [3:0]               per_we_o,
  output logic [31:0]              per_addr_o,
  output logic [31:0]              per_wdata_o,
  input  logic [31:0]              per_rdata_i,
  input  logic                     per_ack_i,
  input  logic                     per_err_i
);

  localparam int              TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_RSP  = 2'd1,
    PER_WAIT = 2'd2,
    RSP      = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [TW-1:0] timer_r;
  logic [3:0]    we_r;
  logic          rsp_ok_r;
  logic [31:0]   rdata_r;

  logic ram_hit_s;
  logic per_hit_s;
  logic accept_s;
  logic timeout_s;

  // RAM takes priority should the two regions ever be configured to overlap.
  assign ram_hit_s = (lsu.addr[31:RAM_SIZE_LOG2] == RAM_BASE[31:RAM_SIZE_LOG2]);
  assign per_hit_s = (lsu.addr[31:PER_SIZE_LOG2] == PER_BASE[31:PER_SIZE_LOG2]) && !ram_hit_s;
  assign accept_s  = lsu.stb && (state_r != PER_WAIT);
  assign timeout_s = (timer_r == TIMER_LAST);

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE, RAM_RSP, RSP: begin
        if (accept_s && ram_hit_s) begin
          state_nxt_s = RAM_RSP;
        end else if (accept_s && per_hit_s) begin
          state_nxt_s = PER_WAIT;
        end else if (accept_s) begin
          state_nxt_s = RSP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PER_WAIT: begin
        if (per_err_i || per_ack_i || timeout_s) begin
          state_nxt_s = RSP;
        end else begin
          state_nxt_s = PER_WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request capture, peripheral handshake, timer and response status.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      per_req_o   <= 1'b0;
      per_we_o    <= 4'h0;
      per_addr_o  <= 32'h0;
      per_wdata_o <= 32'h0;
      timer_r     <= '0;
      we_r        <= 4'h0;
      rsp_ok_r    <= 1'b0;
      rdata_r     <= 32'h0;
    end else if (state_r == PER_WAIT) begin
      if (per_err_i) begin
        rsp_ok_r  <= 1'b0;
        per_req_o <= 1'b0;
      end else if (per_ack_i) begin
        rdata_r   <= (per_we_o == 4'h0) ? per_rdata_i : 32'h0;
        rsp_ok_r  <= 1'b1;
        per_req_o <= 1'b0;
      end else if (timeout_s) begin
        rsp_ok_r  <= 1'b0;
        per_req_o <= 1'b0;
      end else begin
        timer_r   <= timer_r + TW'(1);
      end
    end else if (accept_s) begin
      if (ram_hit_s) begin
        we_r <= lsu.we;
      end else if (per_hit_s) begin
        per_req_o   <= 1'b1;
        per_we_o    <= lsu.we;
        per_addr_o  <= lsu.addr;
        per_wdata_o <= lsu.wdata;
        timer_r     <= '0;
      end else begin
        rsp_ok_r <= 1'b0;
      end
    end
  end

  // RAM port drive, LSU response and overrun flag.
  always_comb begin
    bram_en_o    = 1'b0;
    bram_we_o    = 4'h0;
    bram_addr_o  = '0;
    bram_wdata_o = 32'h0;
    lsu.ack      = 1'b0;
    lsu.err      = 1'b0;
    lsu.rdata    = 32'h0;
    overrun_o    = lsu.stb && (state_r == PER_WAIT);
    if (accept_s && ram_hit_s) begin
      bram_en_o    = 1'b1;
      bram_we_o    = lsu.we;
      bram_addr_o  = lsu.addr[RAM_SIZE_LOG2-1:2];
      bram_wdata_o = lsu.wdata;
    end else begin
      bram_en_o    = 1'b0;
    end
    case (state_r)
      RAM_RSP: begin
        lsu.ack   = 1'b1;
        lsu.rdata = (we_r == 4'h0) ? bram_rdata_i : 32'h0;
      end
      RSP: begin
        lsu.ack   = rsp_ok_r;
        lsu.err   = !rsp_ok_r;
        lsu.rdata = rsp_ok_r ? rdata_r : 32'h0;
      end
      default: begin
        lsu.ack   = 1'b0;
        lsu.err   = 1'b0;
        lsu.rdata = 32'h0;
      end
    endcase
  end

endmodule
